nios_pio_in_edge_irq: RTL and testbench

//   Parametrised Avalon-MM input PIO for Nios II: WIDTH input channels with synchroniser,
//   per-channel debounce, runtime-selectable rising/falling edge capture and masked IRQ.

---
 rtl/nios_pio_in_edge_irq.sv | 142 ++++++++++++++
 tb/tb_nios_pio_in_edge_irq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_pio_in_edge_irq.sv
// Avalon-MM input PIO: per-channel synchroniser, optional debounce, selectable
// rising/falling edge capture with write-1-to-clear and masked level interrupt.
module nios_pio_in_edge_irq #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_RISE = 3'd4;
  localparam logic [2:0] ADDR_FALL = 3'd5;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] edge_cap_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] edge_qual;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic [31:0]      rd_mux;

  assign wr_en = chipselect && !write_n;
  assign wdata = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  // Metastability chain; s is the last stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable_d = s;
    end else begin : g_debounce
      localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q [WIDTH];
      logic [CNT_W-1:0] cnt_d [WIDTH];

      // Any sample agreeing with the stable value restarts the count
      always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_d[i] = cnt_q[i];
          if (s[i] == stable_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = s[i];
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
      end
    end
  endgenerate

  // Edge is judged on the same clock edge that updates stable
  assign edge_qual = (stable_d & ~stable_q & rise_en_q) |
                     (~stable_d & stable_q & fall_en_q);
  assign w1c = (wr_en && address == ADDR_EDGE) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q   <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      rise_en_q  <= '1;
      fall_en_q  <= '0;
    end else begin
      stable_q   <= stable_d;
      edge_cap_q <= (edge_cap_q & ~w1c) | edge_qual;
      if (wr_en) begin
        case (address)
          ADDR_MASK: irq_mask_q <= wdata;
          ADDR_RISE: rise_en_q  <= wdata;
          ADDR_FALL: fall_en_q  <= wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = 32'(stable_q);
      ADDR_MASK: rd_mux = 32'(irq_mask_q);
      ADDR_EDGE: rd_mux = 32'(edge_cap_q);
      ADDR_RISE: rd_mux = 32'(rise_en_q);
      ADDR_FALL: rd_mux = 32'(fall_en_q);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_nios_pio_in_edge_irq.sv
// Bench for nios_pio_in_edge_irq: a no-debounce and a 3-cycle-debounce instance
// share stimulus and are checked every cycle against a queue-based register model.
module tb_nios_pio_in_edge_irq;

  logic        clk;
  logic        reset_n;
  logic        cs;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int total = 0;
  int bad   = 0;

  nios_pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs), .address(address), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));

  nios_pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs), .address(address), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  dq[$];       // in_port samples waiting to emerge from the synchroniser
  logic [3:0]  sh[$];       // last three synchronised samples, newest at back
  logic [3:0]  m_stable[2];
  logic [3:0]  m_cap[2];
  logic [31:0] m_rd[2];
  logic [3:0]  m_mask, m_rise, m_fall;
  logic [3:0]  s_now, nst, qual, w1c;
  logic        wr_now;
  int          differ;

  task automatic model_reset();
    dq.delete(); sh.delete();
    repeat (2) dq.push_back(4'h0);
    repeat (3) sh.push_back(4'h0);
    for (int d = 0; d < 2; d++) begin
      m_stable[d] = 4'h0; m_cap[d] = 4'h0; m_rd[d] = 32'h0;
    end
    m_mask = 4'h0; m_rise = 4'hF; m_fall = 4'h0;
  endtask

  function automatic logic [31:0] reg_read(input logic [2:0] a, input logic [3:0] st,
                                           input logic [3:0] cap);
    case (a)
      3'd0:    return {28'h0, st};
      3'd2:    return {28'h0, m_mask};
      3'd3:    return {28'h0, cap};
      3'd4:    return {28'h0, m_rise};
      3'd5:    return {28'h0, m_fall};
      default: return 32'h0;
    endcase
  endfunction

  initial model_reset();

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      s_now = dq.pop_front();
      dq.push_back(in_port);
      sh.push_back(s_now);
      void'(sh.pop_front());
      wr_now = cs && !write_n;
      w1c = (wr_now && address == 3'd3) ? writedata[3:0] : 4'h0;
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          nst = s_now;
        end else begin
          // a channel flips once three consecutive samples all disagree with it
          nst = m_stable[d];
          for (int b = 0; b < 4; b++) begin
            differ = 0;
            for (int k = 0; k < 3; k++) if (sh[k][b] != m_stable[d][b]) differ++;
            if (differ == 3) nst[b] = ~m_stable[d][b];
          end
        end
        qual = (nst & ~m_stable[d] & m_rise) | (~nst & m_stable[d] & m_fall);
        m_rd[d] = reg_read(address, m_stable[d], m_cap[d]);
        m_cap[d] = (m_cap[d] & ~w1c) | qual;
        m_stable[d] = nst;
      end
      if (wr_now) begin
        case (address)
          3'd2: m_mask = writedata[3:0];
          3'd4: m_rise = writedata[3:0];
          3'd5: m_fall = writedata[3:0];
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("rd0_model",  rd0,         m_rd[0]);
    chk("rd1_model",  rd1,         m_rd[1]);
    chk("irq0_model", 32'(irq0),   32'(|(m_cap[0] & m_mask)));
    chk("irq1_model", 32'(irq1),   32'(|(m_cap[1] & m_mask)));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step(1);
    cs = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; write_n = 1'b1; address = 3'd0;
    writedata = 32'h0; in_port = 4'h0;
    step(2);
    chk("rst_rd", rd0, 32'h0);
    chk("rst_irq", 32'(irq0), 32'h0);
    reset_n = 1'b1; address = 3'd4;
    step(1);
    chk("rise_en_rst", rd0, 32'hF);

    // single rising edge: latency 3 edges without debounce, 5 with
    address = 3'd3; in_port = 4'h1;
    step(3); chk("t1_d0_early", rd0, 32'h0);
    step(1); chk("t1_d0_cap",   rd0, 32'h1);
    step(1); chk("t1_d1_early", rd1, 32'h0);
    step(1); chk("t1_d1_cap",   rd1, 32'h1);
    wr(3'd3, 32'hF);
    step(1); chk("t1_clear", rd0, 32'h0);

    // glitch rejection on channel 2
    in_port = 4'h5; step(2); in_port = 4'h1; step(8);
    chk("t2_glitch_d1", rd1, 32'h0);
    chk("t2_glitch_d0", rd0, 32'h4);
    address = 3'd0; step(1);
    chk("t2_data_d1", rd1, 32'h1);
    wr(3'd3, 32'hF);
    in_port = 4'h5; step(3); in_port = 4'h1; step(8);
    address = 3'd3; step(1);
    chk("t2_pulse_d1", rd1, 32'h4);

    // falling-only capture
    wr(3'd5, 32'hF); wr(3'd4, 32'h0); wr(3'd3, 32'hF);
    in_port = 4'h3; step(9);
    chk("t3_rise_ign", rd0, 32'h0);
    in_port = 4'h1; step(9);
    chk("t3_fall_d0", rd0, 32'h2);
    chk("t3_fall_d1", rd1, 32'h2);

    // masked interrupt and W1C of a single bit
    in_port = 4'h0; step(8);
    wr(3'd2, 32'h2);
    chk("t4_irq_on", 32'(irq0), 32'h1);
    wr(3'd3, 32'h2);
    chk("t4_irq_off", 32'(irq0), 32'h0);
    step(1); chk("t4_cap", rd0, 32'h1);

    // W1C on the very edge a new rise lands: set wins
    wr(3'd4, 32'hF); wr(3'd5, 32'h0); wr(3'd3, 32'hF);
    in_port = 4'h1; step(2);
    wr(3'd3, 32'h1);
    step(1); chk("t5_set_wins", rd0, 32'h1);
    step(2); chk("t5_d1", rd1, 32'h1);

    // asynchronous reset mid-debounce
    in_port = 4'hF; step(9);
    chk("t6_cap_f", rd0, 32'hF);
    chk("t6_irq_pre", 32'(irq0), 32'h1);
    in_port = 4'h0; step(2);
    reset_n = 1'b0; #1;
    chk("t6_rd0_rst",  rd0,        32'h0);
    chk("t6_rd1_rst",  rd1,        32'h0);
    chk("t6_irq0_rst", 32'(irq0),  32'h0);
    chk("t6_irq1_rst", 32'(irq1),  32'h0);
    step(2);
    reset_n = 1'b1; address = 3'd4; step(1);
    chk("t6_rise_en", rd0, 32'hF);
    address = 3'd3; step(6);
    chk("t6_no_cap", rd1, 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
      address   = 3'($urandom_range(0, 7));
      cs        = 1'($urandom_range(0, 1));
      write_n   = ($urandom_range(0, 2) != 0);
      writedata = $urandom;
      reset_n   = ($urandom_range(0, 399) != 0);
      step(1);
    end
    reset_n = 1'b1; cs = 1'b0; write_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
